// File: rtl/seq_mul.sv
// Iterative radix-2 shift-add multiplier with valid/ready handshakes.
// Signed mode multiplies magnitudes and negates the product at the end.
module seq_mul #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_WIDTH-1:0]     a,
    input  logic [DATA_WIDTH-1:0]     b,
    input  logic                      signed_mode,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [2*DATA_WIDTH-1:0]   product,
    output logic [DATA_WIDTH-1:0]     result,
    output logic                      overflow
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [W-1:0]     r_mcand;
    logic [2*W:0]     r_acc;
    logic             r_neg;
    logic             r_signed;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [2*W-1:0]   r_product;
    logic [W-1:0]     r_result;
    logic             r_overflow;

    logic [W-1:0]     w_a_mag;
    logic [W-1:0]     w_b_mag;
    logic             w_neg;
    logic [W:0]       w_add;
    logic [2*W-1:0]   w_mag;
    logic [2*W-1:0]   w_prod;
    logic [W:0]       w_hi;
    logic             w_ovf;

    assign w_a_mag = (signed_mode && a[W-1]) ? -a : a;
    assign w_b_mag = (signed_mode && b[W-1]) ? -b : b;
    assign w_neg   = signed_mode & (a[W-1] ^ b[W-1]);

    // The multiplier lives in the low half of the accumulator, so its LSB
    // is r_acc[0] and it shifts out as product bits shift in.
    assign w_add  = r_acc[2*W:W] + (r_acc[0] ? {1'b0, r_mcand} : '0);
    assign w_mag  = {w_add, r_acc[W-1:1]};
    assign w_prod = r_neg ? -w_mag : w_mag;
    assign w_hi   = w_prod[2*W-1:W-1];
    assign w_ovf  = r_signed ? !((&w_hi) || !(|w_hi))
                             : |w_prod[2*W-1:W];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_mcand     <= '0;
            r_acc       <= '0;
            r_neg       <= 1'b0;
            r_signed    <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_product   <= '0;
            r_result    <= '0;
            r_overflow  <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_mcand    <= w_a_mag;
                        r_acc      <= {{(W+1){1'b0}}, w_b_mag};
                        r_neg      <= w_neg;
                        r_signed   <= signed_mode;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= S_CALC;
                    end
                end
                S_CALC: begin
                    r_acc <= {1'b0, w_mag};
                    if (r_cnt == LAST) begin
                        r_cnt       <= '0;
                        r_product   <= w_prod;
                        r_result    <= w_prod[W-1:0];
                        r_overflow  <= w_ovf;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign product   = r_product;
    assign result    = r_result;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_seq_mul.sv
// Bench for seq_mul: 16-bit and 8-bit instances checked every cycle
// against an arithmetic reference model, plus directed literal vectors.
module tb_seq_mul;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    bit live  = 1'b0;
    bit rand_bp = 1'b0;

    logic        rst_n;
    logic        in_valid, signed_mode, out_ready;
    logic [15:0] a, b;
    logic        in_ready, out_valid, overflow;
    logic [31:0] product;
    logic [15:0] result;

    logic        in_valid8, signed_mode8, out_ready8;
    logic [7:0]  a8, b8;
    logic        in_ready8, out_valid8, overflow8;
    logic [15:0] product8;
    logic [7:0]  result8;

    seq_mul #(.DATA_WIDTH(16)) u16 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .signed_mode(signed_mode),
        .out_valid(out_valid), .out_ready(out_ready),
        .product(product), .result(result), .overflow(overflow)
    );

    seq_mul #(.DATA_WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .signed_mode(signed_mode8),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .product(product8), .result(result8), .overflow(overflow8)
    );

    typedef struct {
        logic [63:0] p;
        bit          ov;
        int          acc;
    } exp_t;

    exp_t q16[$];
    exp_t q8[$];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    // Reference: exact integer product, masked to 2w bits.
    function automatic void model(input int w, input logic [63:0] au,
                                  input logic [63:0] bu, input bit s,
                                  output logic [63:0] prod, output bit ov);
        longint av, bv, p, one;
        one = 1;
        av = longint'(au);
        bv = longint'(bu);
        if (s && au[w-1]) av = av - (one << w);
        if (s && bu[w-1]) bv = bv - (one << w);
        p = av * bv;
        prod = 64'(p) & ((64'd1 << (2 * w)) - 64'd1);
        if (s) ov = (p < -(one << (w - 1))) || (p >= (one << (w - 1)));
        else   ov = (p >= (one << w));
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (rand_bp) begin
            #1;
            out_ready  = 1'($urandom_range(0, 1));
            out_ready8 = 1'($urandom_range(0, 1));
        end
    end

    // Per-cycle compare against the model queues.
    always @(negedge clk) begin
        exp_t e;
        bit   v;
        if (live) begin
            chk("in_ready16", in_ready, q16.size() == 0);
            v = (q16.size() > 0) && (cyc >= q16[0].acc + 17);
            chk("out_valid16", out_valid, v);
            if (out_valid && q16.size() > 0) begin
                chk("product16", product, q16[0].p);
                chk("result16", result, q16[0].p[15:0]);
                chk("overflow16", overflow, q16[0].ov);
            end
            chk("in_ready8", in_ready8, q8.size() == 0);
            v = (q8.size() > 0) && (cyc >= q8[0].acc + 9);
            chk("out_valid8", out_valid8, v);
            if (out_valid8 && q8.size() > 0) begin
                chk("product8", product8, q8[0].p);
                chk("result8", result8, q8[0].p[7:0]);
                chk("overflow8", overflow8, q8[0].ov);
            end
        end
        if (!rst_n) begin
            q16.delete();
            q8.delete();
            live = 1'b1;
        end else if (live) begin
            if (q16.size() > 0 && cyc >= q16[0].acc + 17 && out_ready)
                void'(q16.pop_front());
            else if (q16.size() == 0 && in_valid) begin
                model(16, a, b, signed_mode, e.p, e.ov);
                e.acc = cyc;
                q16.push_back(e);
            end
            if (q8.size() > 0 && cyc >= q8[0].acc + 9 && out_ready8)
                void'(q8.pop_front());
            else if (q8.size() == 0 && in_valid8) begin
                model(8, a8, b8, signed_mode8, e.p, e.ov);
                e.acc = cyc;
                q8.push_back(e);
            end
        end
    end

    task automatic send16(input logic [15:0] ta, input logic [15:0] tb,
                          input bit ts);
        int k = 0;
        @(posedge clk); #1;
        a = ta; b = tb; signed_mode = ts; in_valid = 1'b1;
        while (!in_ready && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        chk("accept16", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = 16'($urandom);
        b = 16'($urandom);
    endtask

    task automatic send8(input logic [7:0] ta, input logic [7:0] tb,
                         input bit ts);
        int k = 0;
        @(posedge clk); #1;
        a8 = ta; b8 = tb; signed_mode8 = ts; in_valid8 = 1'b1;
        while (!in_ready8 && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        chk("accept8", in_ready8, 1);
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        a8 = 8'($urandom);
    endtask

    task automatic wait16(output int k);
        k = 0;
        while (!out_valid && k < 60) begin
            @(posedge clk); #1;
            k++;
        end
        chk("done16", out_valid, 1);
    endtask

    task automatic run16(input logic [15:0] ta, input logic [15:0] tb,
                         input bit ts, input logic [63:0] xp,
                         input bit xov);
        logic [63:0] mp;
        bit          mov;
        int          k;
        model(16, ta, tb, ts, mp, mov);
        chk("model16_p", mp, xp);
        chk("model16_ov", mov, xov);
        send16(ta, tb, ts);
        wait16(k);
        chk("latency16", k, 16);
        chk("lit_prod16", product, xp);
        chk("lit_res16", result, xp[15:0]);
        chk("lit_ovf16", overflow, xov);
        @(posedge clk); #1;
    endtask

    task automatic run8(input logic [7:0] ta, input logic [7:0] tb,
                        input bit ts, input logic [63:0] xp,
                        input bit xov);
        logic [63:0] mp;
        bit          mov;
        int          k = 0;
        model(8, ta, tb, ts, mp, mov);
        chk("model8_p", mp, xp);
        chk("model8_ov", mov, xov);
        send8(ta, tb, ts);
        while (!out_valid8 && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        chk("done8", out_valid8, 1);
        chk("latency8", k, 8);
        chk("lit_prod8", product8, xp);
        chk("lit_res8", result8, xp[7:0]);
        chk("lit_ovf8", overflow8, xov);
        @(posedge clk); #1;
    endtask

    function automatic logic [15:0] pick16();
        unique case ($urandom_range(0, 5))
            0: return 16'h0000;
            1: return 16'h8000;
            2: return 16'hFFFF;
            3: return 16'h0001;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        int k;
        rst_n = 1'b0;
        in_valid = 1'b0; signed_mode = 1'b0; out_ready = 1'b1;
        a = '0; b = '0;
        in_valid8 = 1'b0; signed_mode8 = 1'b0; out_ready8 = 1'b1;
        a8 = '0; b8 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_product", product, 0);
        chk("rst_result", result, 0);
        chk("rst_overflow", overflow, 0);
        rst_n = 1'b1;

        run16(16'hFFFF, 16'hFFFF, 1'b0, 64'hFFFE0001, 1'b1);
        run16(16'hFFFD, 16'h0005, 1'b1, 64'hFFFFFFF1, 1'b0);
        run16(16'hFFFD, 16'h0005, 1'b0, 64'h0004FFF1, 1'b1);
        run16(16'h8000, 16'h8000, 1'b1, 64'h40000000, 1'b1);
        run16(16'h8000, 16'h0001, 1'b1, 64'hFFFF8000, 1'b0);
        run16(16'h0000, 16'h0000, 1'b1, 64'h00000000, 1'b0);

        // Backpressure: result must hold and new requests be ignored.
        out_ready = 1'b0;
        send16(16'h1234, 16'h5678, 1'b0);
        wait16(k);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            in_valid = (i == 2);
            a = 16'hAAAA;
            chk("bp_valid", out_valid, 1);
            chk("bp_ready", in_ready, 0);
            chk("bp_prod", product, 32'h06260060);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_idle_ready", in_ready, 1);
        chk("bp_idle_valid", out_valid, 0);
        run16(16'h0007, 16'hFFFF, 1'b1, 64'hFFFFFFF9, 1'b0);

        // Reset in the middle of an operation aborts it.
        send16(16'h1111, 16'h2222, 1'b0);
        repeat (7) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("abort_ready", in_ready, 1);
        chk("abort_valid", out_valid, 0);
        repeat (20) @(posedge clk);
        #1;
        run16(16'h0007, 16'h0006, 1'b0, 64'h0000002A, 1'b0);

        run8(8'd200, 8'd3, 1'b0, 64'h0258, 1'b1);
        run8(8'h80, 8'hFF, 1'b1, 64'h0080, 1'b1);
        run8(8'h7F, 8'h7F, 1'b1, 64'h3F01, 1'b1);
        run8(8'hF6, 8'h05, 1'b1, 64'hFFCE, 1'b0);

        rand_bp = 1'b1;
        for (int i = 0; i < 30; i++)
            send16(pick16(), pick16(), 1'($urandom_range(0, 1)));
        for (int i = 0; i < 20; i++)
            send8(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
        rand_bp = 1'b0;
        #2;
        out_ready = 1'b1;
        out_ready8 = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        chk("final_idle16", in_ready, 1);
        chk("final_idle8", in_ready8, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/seq_mul.md
Name: seq_mul

Overview:
- Iterative radix-2 shift-add multiplier; parametrised, sequential successor to the combinational array multiplier.
- Returns the full 2*DATA_WIDTH product, the truncated DATA_WIDTH result and an overflow flag.
- Supports per-operation signed (two's complement) or unsigned mode.
- Valid/ready handshakes on input and output, so it can sit between pipeline stages of the datapath and trade area for latency.

Parameters:
- DATA_WIDTH, 16, operand width in bits; legal range 2..32.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- in_valid  input  1  operands and mode are valid.
- in_ready  output  1  block can accept an operation.
- a  input  DATA_WIDTH  multiplicand.
- b  input  DATA_WIDTH  multiplier.
- signed_mode  input  1  1 = operands and result are two's complement; 0 = unsigned.
- out_valid  output  1  product outputs valid.
- out_ready  input  1  consumer accepts the result.
- product  output  2*DATA_WIDTH  full product.
- result  output  DATA_WIDTH  product[DATA_WIDTH-1:0].
- overflow  output  1  product does not fit in DATA_WIDTH bits under the current mode.

Behaviour:
- Clocking and reset:
  - One clock; reset is synchronous and active-low (rst_n sampled on the rising edge of clk).
  - While rst_n=0 at an edge: state=IDLE, in_ready=1 (after the edge), out_valid=0, product=0, result=0, overflow=0, iteration counter=0.
  - Reset has priority over every other event; asserting it mid-CALC or in DONE aborts the operation with no output.
- States:
  - IDLE: in_ready=1, out_valid=0.
  - CALC: in_ready=0, out_valid=0.
  - DONE: in_ready=0, out_valid=1.
- Transitions:
  - IDLE -> CALC on the edge where in_valid&in_ready; that edge latches a, b, signed_mode.
  - CALC -> DONE on the edge where the counter reaches DATA_WIDTH-1 (last iteration).
  - DONE -> IDLE on the edge where out_valid&out_ready.
  - Inputs are ignored when in_ready=0.
- Latency and throughput:
  - out_valid rises exactly DATA_WIDTH edges after the accepting edge.
  - No accept in the same cycle as the result handshake; minimum initiation interval is DATA_WIDTH+2 cycles.
- Operand preprocessing at accept:
  - Signed mode: store the magnitudes |a| and |b| as DATA_WIDTH-bit unsigned values, plus neg = a[MSB]^b[MSB].
  - The most negative value has magnitude 2^(DATA_WIDTH-1), which is representable.
  - Unsigned mode: neg=0, operands stored as-is.
- Iteration (one per CALC cycle, DATA_WIDTH total):
  - If the multiplier LSB is 1, add the multiplicand (zero-extended) into the upper half of a 2*DATA_WIDTH+1-bit accumulator.
  - Then shift the accumulator right by 1 and shift the multiplier right by 1.
  - No carry may be lost.
- Finish, on the CALC->DONE edge:
  - product = neg ? two's complement of the magnitude : magnitude.
  - result = product[DATA_WIDTH-1:0].
  - overflow: unsigned mode = |product[2W-1:W]|; signed mode = product[2W-1:W-1] not all-equal.
- Hold: product, result and overflow stay stable while out_valid=1 and out_ready=0. They also hold their last value in IDLE and CALC (consumers qualify them with out_valid).
- Zero operands take the full DATA_WIDTH cycles; there is no early termination.

Test Plan:
- Reset: rst_n=0 one edge -> in_ready=1, out_valid=0, product=0, overflow=0. Then unsigned 0xFFFF*0xFFFF -> out_valid exactly 16 edges after accept, product=0xFFFE0001, result=0x0001, overflow=1.
- Signed -3*5 (a=0xFFFD, b=0x0005, signed_mode=1) -> product=0xFFFFFFF1, result=0xFFF1, overflow=0. Same operands unsigned -> product=0x0004FFF1, overflow=1.
- Signed corner 0x8000*0x8000 -> product=0x40000000, overflow=1. Signed 0x8000*0x0001 -> product=0xFFFF8000, overflow=0.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> outputs stable, in_ready=0, and a new in_valid pulse is ignored. Then out_ready=1 -> IDLE next edge, and the next operation computes correctly.
- Reset mid-operation: assert rst_n=0 at iteration 7 -> next edge IDLE, out_valid never asserts. Then 7*6 unsigned -> product=0x0000002A.
- DATA_WIDTH=8 instance: unsigned 200*3 -> product=0x0258, result=0x58, overflow=1, latency 8 edges. Signed 0x80*0xFF -> product=0x0080, overflow=1.
